// File: rtl/unidade_controle_contagem_pkg.sv
// Shared types and defaults for the counting control unit and its step counter.
package unidade_controle_contagem_pkg;

    localparam int MAX_PASSOS_PADRAO = 16;
    localparam int PASSOS_W_PADRAO   = 8;

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        PREPARA = 4'h1,
        COMPARA = 4'h3,
        PROXIMO = 4'h4,
        ACERTO  = 4'hA,
        ERRO    = 4'hE
    } estado_t;

endpackage

// File: rtl/unidade_controle_contagem_contador_passos.sv
// Saturating step counter: counts conta pulses in a run and flags when the limit is reached.
module contador_passos #(
    parameter int MAX_PASSOS = 16,
    parameter int PASSOS_W   = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                limpa,
    input  logic                incrementa,
    output logic [PASSOS_W-1:0] passos,
    output logic                no_limite
);

    localparam logic [PASSOS_W-1:0] LIMITE = PASSOS_W'(MAX_PASSOS);

    logic [PASSOS_W-1:0] passos_reg;
    logic [PASSOS_W-1:0] passos_next;

    // Holds at the limit instead of wrapping, so a runaway run still reports the limit.
    always_comb begin
        passos_next = passos_reg;
        if (limpa) begin
            passos_next = '0;
        end else if (incrementa && (passos_reg != LIMITE)) begin
            passos_next = passos_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            passos_reg <= '0;
        end else begin
            passos_reg <= passos_next;
        end
    end

    assign passos    = passos_reg;
    assign no_limite = (passos_reg == LIMITE);

endmodule

// File: rtl/unidade_controle_contagem.sv
// Moore control unit stepping the counter/comparator datapath up to the switch value.
module unidade_controle_contagem
    import unidade_controle_contagem_pkg::*;
#(
    parameter int MAX_PASSOS = MAX_PASSOS_PADRAO,
    parameter int PASSOS_W   = PASSOS_W_PADRAO
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                iniciar,
    input  logic                fim,
    input  logic                igual,
    input  logic                menor,
    input  logic                maior,
    output logic                zera,
    output logic                carrega,
    output logic                conta,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic [3:0]          db_estado,
    output logic [PASSOS_W-1:0] db_passos
);

    estado_t estado_reg;
    estado_t estado_next;
    logic    limpa_passos;
    logic    incrementa_passos;
    logic    no_limite;

    // menor is redundant with !igual && !maior and only exists for datapath debug.
    logic unused_menor;
    assign unused_menor = menor;

    contador_passos #(
        .MAX_PASSOS (MAX_PASSOS),
        .PASSOS_W   (PASSOS_W)
    ) u_contador_passos (
        .clock      (clock),
        .reset_n    (reset_n),
        .limpa      (limpa_passos),
        .incrementa (incrementa_passos),
        .passos     (db_passos),
        .no_limite  (no_limite)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_reg <= INICIAL;
        end else begin
            estado_reg <= estado_next;
        end
    end

    always_comb begin
        estado_next       = estado_reg;
        zera              = 1'b0;
        conta             = 1'b0;
        pronto            = 1'b0;
        acertou           = 1'b0;
        errou             = 1'b0;
        limpa_passos      = 1'b0;
        incrementa_passos = 1'b0;
        case (estado_reg)
            INICIAL: begin
                if (iniciar) estado_next = PREPARA;
            end
            PREPARA: begin
                zera         = 1'b1;
                limpa_passos = 1'b1;
                estado_next  = COMPARA;
            end
            // igual is checked first so reaching 15 counts as success even with fim set.
            COMPARA: begin
                if (igual)          estado_next = ACERTO;
                else if (maior)     estado_next = ERRO;
                else if (fim)       estado_next = ERRO;
                else if (no_limite) estado_next = ERRO;
                else                estado_next = PROXIMO;
            end
            PROXIMO: begin
                conta             = 1'b1;
                incrementa_passos = 1'b1;
                estado_next       = COMPARA;
            end
            ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                if (iniciar) estado_next = PREPARA;
            end
            ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
                if (iniciar) estado_next = PREPARA;
            end
            default: begin
                estado_next = INICIAL;
            end
        endcase
    end

    assign carrega   = 1'b0;
    assign db_estado = estado_reg;

endmodule

// File: tb/tb_unidade_controle_contagem.sv
// Bench for unidade_controle_contagem: two builds (limit 16 and 3) driving modelled datapaths.
module tb_unidade_controle_contagem;

    logic       clock;
    logic       reset_n;
    logic       iniciar;
    logic [3:0] chaves;
    logic       sel;

    logic [3:0] cnt_a, cnt_b;
    logic       fim_a, igual_a, menor_a, maior_a;
    logic       fim_b, igual_b, menor_b, maior_b;
    logic       zera_a, carrega_a, conta_a, pronto_a, acertou_a, errou_a;
    logic       zera_b, carrega_b, conta_b, pronto_b, acertou_b, errou_b;
    logic [3:0] estado_a, estado_b;
    logic [7:0] passos_a, passos_b;

    logic       o_zera, o_carrega, o_conta, o_pronto, o_acertou, o_errou;
    logic [3:0] o_estado;
    logic [7:0] o_passos;

    int n_checks = 0;
    int n_pass   = 0;

    unidade_controle_contagem dut_a (
        .clock(clock), .reset_n(reset_n), .iniciar(iniciar),
        .fim(fim_a), .igual(igual_a), .menor(menor_a), .maior(maior_a),
        .zera(zera_a), .carrega(carrega_a), .conta(conta_a), .pronto(pronto_a),
        .acertou(acertou_a), .errou(errou_a), .db_estado(estado_a), .db_passos(passos_a)
    );

    unidade_controle_contagem #(.MAX_PASSOS(3), .PASSOS_W(8)) dut_b (
        .clock(clock), .reset_n(reset_n), .iniciar(iniciar),
        .fim(fim_b), .igual(igual_b), .menor(menor_b), .maior(maior_b),
        .zera(zera_b), .carrega(carrega_b), .conta(conta_b), .pronto(pronto_b),
        .acertou(acertou_b), .errou(errou_b), .db_estado(estado_b), .db_passos(passos_b)
    );

    // 74163/7485-style datapath models; fim is the counter's terminal count.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)     cnt_a <= 4'd0;
        else if (zera_a)  cnt_a <= 4'd0;
        else if (conta_a) cnt_a <= cnt_a + 4'd1;
    end
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)     cnt_b <= 4'd0;
        else if (zera_b)  cnt_b <= 4'd0;
        else if (conta_b) cnt_b <= cnt_b + 4'd1;
    end
    assign fim_a   = (cnt_a == 4'd15);
    assign igual_a = (cnt_a == chaves);
    assign menor_a = (cnt_a < chaves);
    assign maior_a = (cnt_a > chaves);
    assign fim_b   = (cnt_b == 4'd15);
    assign igual_b = (cnt_b == chaves);
    assign menor_b = (cnt_b < chaves);
    assign maior_b = (cnt_b > chaves);

    always_comb begin
        o_zera    = sel ? zera_b    : zera_a;
        o_carrega = sel ? carrega_b : carrega_a;
        o_conta   = sel ? conta_b   : conta_a;
        o_pronto  = sel ? pronto_b  : pronto_a;
        o_acertou = sel ? acertou_b : acertou_a;
        o_errou   = sel ? errou_b   : errou_a;
        o_estado  = sel ? estado_b  : estado_a;
        o_passos  = sel ? passos_b  : passos_a;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit sel;
        int chaves;
        int muda;     // passos value at which chaves is changed, -1 = never
        int nova;
        bit ruido;    // toggle iniciar randomly while the run is in progress
        int acertou;
        int errou;
        int passos;
        int ciclos;   // edges from raising iniciar until pronto is seen
    } caso_t;

    caso_t tabela[8];
    caso_t sb[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nome, input int atual, input int esperado);
        n_checks++;
        if (atual == esperado) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    endtask

    task automatic executa(input int idx, input caso_t c);
        caso_t esp;
        int    ciclos, n_conta, n_zera, dupla;
        bit    conta_ant, mudou;
        sel    = c.sel;
        chaves = 4'(c.chaves);
        sb.push_back(c);
        tick();
        iniciar   = 1'b1;
        ciclos    = 0;
        n_conta   = 0;
        n_zera    = 0;
        dupla     = 0;
        conta_ant = 1'b0;
        mudou     = 1'b0;
        do begin
            tick();
            ciclos++;
            iniciar = c.ruido ? 1'($urandom_range(0, 1)) : 1'b0;
            if (o_zera) n_zera++;
            if (o_conta) begin
                n_conta++;
                if (conta_ant) dupla++;
            end
            conta_ant = o_conta;
            if (c.muda >= 0 && !mudou && o_estado == 4'h3 && int'(o_passos) == c.muda) begin
                chaves = 4'(c.nova);
                mudou  = 1'b1;
            end
        end while (!o_pronto && ciclos < 100);
        iniciar = 1'b0;
        esp = sb.pop_front();
        $display("run %0d: dut=%0d chaves=%0d edges=%0d passos=%0d acertou=%0d errou=%0d",
                 idx, c.sel, c.chaves, ciclos, o_passos, o_acertou, o_errou);
        chk("pronto_timeout", int'(o_pronto), 1);
        chk("acertou", int'(o_acertou), esp.acertou);
        chk("errou", int'(o_errou), esp.errou);
        chk("db_passos", int'(o_passos), esp.passos);
        chk("latencia", ciclos, esp.ciclos);
        chk("pulsos_conta", n_conta, esp.passos);
        chk("pulsos_zera", n_zera, 1);
        chk("conta_dupla", dupla, 0);
        chk("estado_final", int'(o_estado), (esp.acertou == 1) ? 10 : 14);
        repeat (30) tick();
    endtask

    initial begin
        int espera;
        tabela[0] = '{1'b0,  5, -1, 0, 1'b0, 1, 0,  5, 13};
        tabela[1] = '{1'b0,  0, -1, 0, 1'b0, 1, 0,  0,  3};
        tabela[2] = '{1'b0, 15, -1, 0, 1'b0, 1, 0, 15, 33};
        tabela[3] = '{1'b0,  9,  4, 2, 1'b0, 0, 1,  4, 11};
        tabela[4] = '{1'b1,  7, -1, 0, 1'b0, 0, 1,  3,  9};
        tabela[5] = '{1'b1,  2, -1, 0, 1'b0, 1, 0,  2,  7};
        tabela[6] = '{1'b0,  6, -1, 0, 1'b1, 1, 0,  6, 15};
        tabela[7] = '{1'b1,  3, -1, 0, 1'b0, 1, 0,  3,  9};

        sel     = 1'b0;
        iniciar = 1'b0;
        chaves  = 4'd0;
        reset_n = 1'b0;
        #3;
        chk("reset_saidas", int'({o_zera, o_carrega, o_conta, o_pronto, o_acertou, o_errou}), 0);
        chk("reset_estado", int'(o_estado), 0);
        chk("reset_passos", int'(o_passos), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("ocioso_saidas", int'({o_zera, o_carrega, o_conta, o_pronto, o_acertou, o_errou}), 0);
        chk("ocioso_estado", int'(o_estado), 0);

        for (int i = 0; i < 8; i++) executa(i, tabela[i]);

        // Reset asserted in the middle of a PROXIMO cycle.
        sel    = 1'b0;
        chaves = 4'd9;
        tick();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        espera  = 0;
        while (!(o_estado == 4'h4 && o_passos == 8'd2) && espera < 50) begin
            tick();
            espera++;
        end
        chk("proximo_alcancado", int'(o_estado), 4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_meio_conta", int'(o_conta), 0);
        chk("reset_meio_estado", int'(o_estado), 0);
        chk("reset_meio_passos", int'(o_passos), 0);
        chk("reset_meio_saidas", int'({o_zera, o_pronto, o_acertou, o_errou}), 0);
        $display("reset mid-PROXIMO: estado=%0d conta=%0d", o_estado, o_conta);
        tick();
        reset_n = 1'b1;
        tick();
        chk("pos_reset_estado", int'(o_estado), 0);

        // iniciar held high across ACERTO restarts immediately.
        chaves = 4'd1;
        tick();
        iniciar = 1'b1;
        espera  = 0;
        do begin
            tick();
            espera++;
        end while (!o_pronto && espera < 50);
        chk("segurado_acertou", int'(o_acertou), 1);
        chk("segurado_latencia", espera, 5);
        tick();
        chk("reinicio_estado", int'(o_estado), 1);
        chk("reinicio_zera", int'(o_zera), 1);
        chk("reinicio_pronto", int'(o_pronto), 0);
        iniciar = 1'b0;
        espera  = 0;
        while (!o_pronto && espera < 50) begin
            tick();
            espera++;
        end
        chk("segunda_acertou", int'(o_acertou), 1);
        chk("segunda_passos", int'(o_passos), 1);
        $display("held iniciar: second run passos=%0d acertou=%0d", o_passos, o_acertou);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/unidade_controle_contagem.md
Name: unidade_controle_contagem

Overview:
- Moore control unit that sequences the counter/comparator datapath (74163-style counter plus 7485-style comparator against the switch value).
- Drives the datapath's `zera`, `carrega` and `conta` inputs, and reads back its `fim`, `igual`, `menor` and `maior` outputs.
- On `iniciar`, clears the counter and steps it one value at a time until it equals the switch value. Signals success, or error on overshoot, wrap or step limit.
- A top-level wrapper instantiates this block alongside the datapath.

Parameters:
- MAX_PASSOS, 16, maximum number of `conta` pulses per run before forced error (1..255).
- PASSOS_W, 8, width of the internal step counter; must hold MAX_PASSOS.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- iniciar  in  1  start request; level, sampled each clock.
- fim  in  1  datapath rco (counter = 15 with enable).
- igual  in  1  datapath counter == chaves.
- menor  in  1  datapath counter < chaves (debug only, no transition effect).
- maior  in  1  datapath counter > chaves.
- zera  out  1  synchronous counter clear request to datapath.
- carrega  out  1  counter load request; tied 0 in this revision, port kept for datapath compatibility.
- conta  out  1  counter enable, one-cycle pulses.
- pronto  out  1  run finished (held).
- acertou  out  1  run finished with igual.
- errou  out  1  run finished by overshoot, wrap or step limit.
- db_estado  out  4  current state encoding.
- db_passos  out  PASSOS_W  steps taken in current/last run.

Behaviour:
- reset_n=0 forces the following immediately, independent of clock:
  - state INICIAL;
  - passos=0;
  - all outputs 0;
  - db_estado=4'h0.
- Reset mid-run aborts the run with no pulse on any output.
- Outputs are Moore, decoded from the state register only.
- Inputs are sampled on the rising clock edge.
- States, with encodings:
  - INICIAL=0
  - PREPARA=1
  - COMPARA=3
  - PROXIMO=4
  - ACERTO=A
  - ERRO=E
  - Unused codes decode to INICIAL.
- INICIAL: all outputs 0. iniciar=1 -> PREPARA; else stay.
- PREPARA: zera=1 for exactly one cycle; passos cleared; -> COMPARA. The datapath counter reads 0 from the next cycle.
- COMPARA: zera=0, conta=0. Transition priority:
  1. igual -> ACERTO.
  2. maior -> ERRO.
  3. fim -> ERRO.
  4. passos==MAX_PASSOS -> ERRO.
  5. Otherwise -> PROXIMO.
- PROXIMO: conta=1 for exactly one cycle; passos increments at exit edge; -> COMPARA.
  - The counter increments on the same edge, so COMPARA always sees the updated value.
- ACERTO: pronto=1, acertou=1. iniciar=1 -> PREPARA (new run); else stay.
- ERRO: pronto=1, errou=1. iniciar=1 -> PREPARA; else stay.
- iniciar is ignored in PREPARA, COMPARA and PROXIMO.
  - Held high, it restarts immediately from ACERTO/ERRO; pronto then drops one cycle later.
- acertou and errou are never both 1; both are 1 only together with pronto.
- Latency: iniciar sampled at edge k gives PREPARA at k+1 and COMPARA at k+2.
  - Switch value N held stable: ACERTO at edge k+3+2N; db_passos=N.
- Boundaries:
  - chaves=0: ACERTO after zero conta pulses.
  - chaves=15: 15 pulses, igual wins over fim.
  - chaves lowered mid-run below the counter value: maior gives ERRO at the next COMPARA.
  - passos saturates at MAX_PASSOS, never wraps.
  - MAX_PASSOS < N: ERRO with db_passos=MAX_PASSOS.

Decomposition:
- Shared package:
  - 4-bit state type and the six encodings;
  - default MAX_PASSOS;
  - PASSOS_W.
- Natural sub-module: contador_passos, a saturating up-counter with clear, enable and terminal flag at MAX_PASSOS.
- The FSM itself stays in one next-state block plus one state register.

Test Plan:
- Reset held low, then released with iniciar=0 -> db_estado=0, all outputs 0. Assert reset_n=0 mid-PROXIMO -> conta=0 immediately, state 0.
- chaves=5 modelled datapath, pulse iniciar -> exactly 5 single-cycle conta pulses, one zera pulse, ACERTO at k+13, acertou=1, db_passos=5.
- chaves=0 -> no conta pulses, ACERTO at k+3. chaves=15 -> 15 pulses, acertou=1 despite fim=1 at the final compare.
- chaves=9, changed to 2 after 4 steps -> maior -> ERRO, errou=1, pronto=1, acertou=0, db_passos=4.
- MAX_PASSOS=3 build, chaves=7 -> ERRO after 3 pulses, db_passos=3.
- iniciar held high through ACERTO -> immediate PREPARA with zera=1; new run completes again. iniciar pulsed during COMPARA/PROXIMO -> no effect on the sequence.
